// File: rtl/neural_pkg.sv
// Shared definitions for the neuron PIO bridge: opcodes, FSM states,
// command/response field positions and the Q8.8 fraction width.
package neural_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_WR_WEIGHT = 3'd1,
        OP_WR_INPUT  = 3'd2,
        OP_SET_BIAS  = 3'd3,
        OP_RUN       = 3'd4,
        OP_CLR_ERR   = 3'd5,
        OP_RSV6      = 3'd6,
        OP_RSV7      = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_SAT,
        S_ACK
    } state_e;

    // command word fields
    localparam int CMD_TOG_BIT  = 31;
    localparam int CMD_OP_LSB   = 28;
    localparam int CMD_ADDR_LSB = 16;
    localparam int CMD_ADDR_W   = 12;
    localparam int DATA_W       = 16;

    // response word fields
    localparam int RSP_ACK_BIT  = 31;
    localparam int RSP_BUSY_BIT = 30;
    localparam int RSP_ERR_BIT  = 29;

    // Q8.8 fixed point
    localparam int FRAC_W = 8;

endpackage

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate with Q8.8 rescale and 16-bit saturation.
// Optional macro NEURON_RELU_EN clamps negative saturated results to zero.
module neuron_mac
    import neural_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                en,
    input  logic signed [15:0]  bias,
    input  logic signed [15:0]  w,
    input  logic signed [15:0]  x,
    output logic [15:0]         sat_res
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [31:0]      prod;
    logic [15:0]             sat;

    assign prod   = 32'(w) * 32'(x);
    assign acc_sh = acc >>> FRAC_W;

    // accumulator: preload with bias in Q16.16, then add one product per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (start)
            acc <= ACC_W'(bias) <<< FRAC_W;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

    // rescale to Q8.8 and saturate to the signed 16-bit range
    always_comb begin
        if (acc_sh > MAX_V)
            sat = 16'h7FFF;
        else if (acc_sh < MIN_V)
            sat = 16'h8000;
        else
            sat = acc_sh[15:0];
`ifdef NEURON_RELU_EN
        if (sat[15])
            sat = '0;
`else
        sat = sat;
`endif
        sat_res = sat;
    end

endmodule

// File: rtl/neuron_pio_bridge.sv
// PIO command bridge for a single MAC neuron. Commands arrive as a toggle
// handshake on to_hw_port_export; status/result return on to_sw_port_export.
// Optional macro NEURON_RELU_EN (in neuron_mac) enables ReLU on the result.
module neuron_pio_bridge
    import neural_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ACC_W = 40
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] to_hw_port_export,
    output logic [31:0] to_sw_port_export,
    output logic [7:0]  led_out
);

    localparam int AW = $clog2(DEPTH);

    state_e state, state_nx;

    logic                  cmd_tog;
    opcode_e               cmd_op;
    logic [CMD_ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0]     cmd_data;
    logic                  accept, addr_ok, run_ok, busy;

    logic                  last_tog, ack_tog, err;
    logic [15:0]           bias, result, sat_res;
    logic [CMD_ADDR_W-1:0] n_cnt, idx;

    logic [15:0]           w_mem [DEPTH];
    logic [15:0]           x_mem [DEPTH];
    logic [15:0]           w_q, x_q;
    logic [AW-1:0]         mem_addr;
    logic                  we_w, we_x;

    assign cmd_tog  = to_hw_port_export[CMD_TOG_BIT];
    assign cmd_op   = opcode_e'(to_hw_port_export[CMD_OP_LSB +: 3]);
    assign cmd_addr = to_hw_port_export[CMD_ADDR_LSB +: CMD_ADDR_W];
    assign cmd_data = to_hw_port_export[DATA_W-1:0];

    assign accept  = (state == S_IDLE) && (cmd_tog != last_tog);
    assign addr_ok = 32'(cmd_addr) < DEPTH;
    assign run_ok  = 32'(cmd_addr) <= DEPTH;
    assign we_w    = accept && (cmd_op == OP_WR_WEIGHT) && addr_ok;
    assign we_x    = accept && (cmd_op == OP_WR_INPUT) && addr_ok;
    assign busy    = (state != S_IDLE);

    // single memory address: write target on a write, else the next read index
    // (entry 0 while idle so a RUN starts with w[0]/x[0] already registered)
    always_comb begin
        mem_addr = '0;
        if (state == S_MAC)
            mem_addr = AW'(idx + 12'd1);
        else if (we_w || we_x)
            mem_addr = AW'(cmd_addr);
    end

    // weight/input memories: synchronous single-port, no reset
    always_ff @(posedge clk_clk) begin
        if (we_w)
            w_mem[mem_addr] <= cmd_data;
        if (we_x)
            x_mem[mem_addr] <= cmd_data;
        w_q <= w_mem[mem_addr];
        x_q <= x_mem[mem_addr];
    end

    // FSM state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // FSM next state; a RUN with N=0 has no products and goes straight to SAT
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_RUN && run_ok)
                        state_nx = (cmd_addr == '0) ? S_SAT : S_MAC;
                    else
                        state_nx = S_ACK;
                end
            end
            S_MAC:   if (idx == n_cnt - 12'd1) state_nx = S_SAT;
            S_SAT:   state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // command side effects, product counter, result capture and ack toggle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            last_tog <= 1'b0;
            ack_tog  <= 1'b0;
            err      <= 1'b0;
            bias     <= '0;
            result   <= '0;
            n_cnt    <= '0;
            idx      <= '0;
        end else begin
            if (accept) begin
                last_tog <= cmd_tog;
                n_cnt    <= cmd_addr;
                idx      <= '0;
                case (cmd_op)
                    OP_WR_WEIGHT,
                    OP_WR_INPUT: if (!addr_ok) err <= 1'b1;
                    OP_SET_BIAS: bias <= cmd_data;
                    OP_RUN:      if (!run_ok) err <= 1'b1;
                    OP_CLR_ERR:  err <= 1'b0;
                    OP_RSV6,
                    OP_RSV7:     err <= 1'b1;
                    default:     ;
                endcase
            end
            if (state == S_MAC)
                idx <= idx + 12'd1;
            if (state == S_SAT)
                result <= sat_res;
            if (state == S_ACK)
                ack_tog <= last_tog;
        end
    end

    neuron_mac #(.ACC_W(ACC_W)) u_mac (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .start   (accept && cmd_op == OP_RUN),
        .en      (state == S_MAC),
        .bias    (bias),
        .w       (w_q),
        .x       (x_q),
        .sat_res (sat_res)
    );

    assign to_sw_port_export = {ack_tog, busy, err, 13'b0, result};
    assign led_out           = busy ? 8'hFF : result[15:8];

endmodule

// File: tb/tb_neuron_pio_bridge.sv
// Self-checking bench for neuron_pio_bridge: a cycle-indexed reference model
// predicts the response word and LEDs every cycle; directed literal checks
// pin the model on the key scenarios.
module tb_neuron_pio_bridge;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] to_hw = '0;
    logic [31:0] to_sw;
    logic [7:0]  led;

    neuron_pio_bridge #(.DEPTH(DEPTH), .ACC_W(40)) dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .to_hw_port_export (to_hw),
        .to_sw_port_export (to_sw),
        .led_out           (led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic tog = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 30)
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_w [DEPTH];
    logic [15:0] m_x [DEPTH];
    logic [15:0] m_bias, m_result, p_res;
    logic        m_ack, m_err, m_last, p_ack;
    int          idle_at, t_res, t_ack;

    function automatic logic [15:0] model_run(input int n);
        longint s;
        s = longint'($signed(m_bias)) * 256;
        for (int i = 0; i < n; i++)
            s += longint'($signed(m_w[i])) * longint'($signed(m_x[i]));
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic model_accept();
        logic [2:0] op;
        int a;
        op = to_hw[30:28];
        a  = int'(to_hw[27:16]);
        m_last = to_hw[31];
        p_ack  = m_last;
        t_ack  = cyc + 2;
        idle_at = cyc + 2;
        case (op)
            3'd1: if (a < DEPTH) m_w[a] = to_hw[15:0]; else m_err = 1'b1;
            3'd2: if (a < DEPTH) m_x[a] = to_hw[15:0]; else m_err = 1'b1;
            3'd3: m_bias = to_hw[15:0];
            3'd4: begin
                if (a > DEPTH) m_err = 1'b1;
                else begin
                    p_res   = model_run(a);
                    t_res   = cyc + a + 2;
                    t_ack   = cyc + a + 3;
                    idle_at = cyc + a + 3;
                end
            end
            3'd5: m_err = 1'b0;
            3'd6, 3'd7: m_err = 1'b1;
            default: ;
        endcase
    endtask

    // compare process: check this cycle's outputs, then let the model see this cycle's input
    always @(negedge clk) begin
        logic busy;
        if (rst) begin
            m_ack = 0; m_err = 0; m_last = 0; m_bias = '0; m_result = '0;
            idle_at = cyc; t_res = -1; t_ack = -1;
        end
        if (cyc == t_res) m_result = p_res;
        if (cyc == t_ack) m_ack = p_ack;
        busy = !rst && (cyc < idle_at);
        chk("rsp", to_sw, {m_ack, busy, m_err, 13'b0, m_result});
        chk("led", 32'(led), 32'(busy ? 8'hFF : m_result[15:8]));
        if (!rst && cyc >= idle_at && to_hw[31] != m_last)
            model_accept();
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] op, input int a, input logic [15:0] d, output int lat);
        int t0;
        logic [11:0] a12;
        a12 = a[11:0];
        @(posedge clk); #1;
        tog   = ~tog;
        to_hw = {tog, op, a12, d};
        t0    = cyc;
        lat   = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (to_sw[31] == tog) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 32'(lat), 32'(0));
    endtask

    initial begin
        int lat, t0, t1, t2, n;
        logic prev;
        logic [2:0] op;
        logic [15:0] held;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp", to_sw, 32'h0);
        chk("reset_led", 32'(led), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // fill both memories
        for (int i = 0; i < DEPTH; i++) begin
            issue(3'd1, i, 16'($urandom), lat);
            issue(3'd2, i, 16'($urandom), lat);
        end
        chk("lat_nonrun", 32'(lat), 32'd2);

        // basic run, N=1
        issue(3'd1, 0, 16'h0100, lat);
        issue(3'd2, 0, 16'h0200, lat);
        issue(3'd3, 0, 16'h0080, lat);
        issue(3'd4, 1, 16'h0, lat);
        chk("run1_lat", 32'(lat), 32'd4);
        chk("run1_res", 32'(to_sw[15:0]), 32'h0280);
        chk("run1_model", 32'(m_result), 32'h0280);

        // positive saturation, N=4
        for (int i = 0; i < 4; i++) begin
            issue(3'd1, i, 16'h7FFF, lat);
            issue(3'd2, i, 16'h7FFF, lat);
        end
        issue(3'd3, 0, 16'h0000, lat);
        issue(3'd4, 4, 16'h0, lat);
        chk("sat_lat", 32'(lat), 32'd7);
        chk("sat_res", 32'(to_sw[15:0]), 32'h7FFF);
        chk("sat_err", 32'(to_sw[29]), 32'h0);

        // negative result, ReLU-dependent
        issue(3'd1, 0, 16'hFF00, lat);
        issue(3'd2, 0, 16'h0100, lat);
        issue(3'd4, 1, 16'h0, lat);
`ifdef NEURON_RELU_EN
        chk("neg_res", 32'(to_sw[15:0]), 32'h0000);
`else
        chk("neg_res", 32'(to_sw[15:0]), 32'h0000FF00);
`endif

        // N=0 returns saturated bias
        issue(3'd3, 0, 16'h1234, lat);
        issue(3'd4, 0, 16'h0, lat);
        chk("run0_lat", 32'(lat), 32'd3);
        chk("run0_res", 32'(to_sw[15:0]), 32'h1234);

        // error paths
        issue(3'd1, 64, 16'h5555, lat);
        chk("wr_oob_err", 32'(to_sw[29]), 32'h1);
        held = to_sw[15:0];
        issue(3'd4, 65, 16'h0, lat);
        chk("run_oob_lat", 32'(lat), 32'd2);
        chk("run_oob_err", 32'(to_sw[29]), 32'h1);
        chk("run_oob_held", 32'(to_sw[15:0]), 32'(held));
        issue(3'd4, DEPTH, 16'h0, lat);
        chk("run_full_lat", 32'(lat), 32'(DEPTH + 3));
        issue(3'd5, 0, 16'h0, lat);
        chk("clr_err", 32'(to_sw[29]), 32'h0);
        issue(3'd6, 0, 16'h0, lat);
        chk("op6_err", 32'(to_sw[29]), 32'h1);
        issue(3'd5, 0, 16'h0, lat);

        // toggle while busy: second command waits for the first IDLE cycle
        @(posedge clk); #1;
        tog = ~tog; to_hw = {tog, 3'd4, 12'd8, 16'h0}; t0 = cyc;
        prev = to_sw[31];
        repeat (3) @(posedge clk); #1;
        tog = ~tog; to_hw = {tog, 3'd3, 12'd0, 16'h0042};
        t1 = -1; t2 = -1;
        for (int i = 0; i < 100 && t2 < 0; i++) begin
            @(negedge clk);
            if (to_sw[31] != prev) begin
                if (t1 < 0) t1 = cyc - t0; else t2 = cyc - t0;
                prev = to_sw[31];
            end
        end
        chk("pend_ack1", 32'(t1), 32'd11);
        chk("pend_ack2", 32'(t2), 32'd13);

        // randomized commands
        for (int k = 0; k < 150; k++) begin
            op = 3'($urandom_range(0, 7));
            case (op)
                3'd1, 3'd2: n = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
                3'd4: n = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 2)) : int'($urandom_range(0, 12));
                default: n = int'($urandom_range(0, 4095));
            endcase
            issue(op, n, 16'($urandom), lat);
        end

        // reset during MAC aborts without ack; a pending toggle=1 is a fresh command
        issue(3'd5, 0, 16'h0, lat);
        @(posedge clk); #1;
        tog = ~tog; to_hw = {tog, 3'd4, 12'd20, 16'h0};
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        tog = 1'b1; to_hw = {1'b1, 3'd0, 12'd0, 16'h0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_reset_rsp", to_sw, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; t0 = cyc; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (to_sw[31]) begin lat = cyc - t0; break; end
        end
        chk("post_reset_ack", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_pio_bridge.md
NEURON_PIO_BRIDGE -- requirements
Module: neuron_pio_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning weight/input entries (power of two, 2..4096).
REQ-002 SHALL have parameter ACC_W, default 40, meaning signed MAC accumulator width.
REQ-003 SHALL have port clk_clk  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port reset_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port to_hw_port_export  input  32  command word from SoC PIO.
REQ-006 SHALL have port to_sw_port_export  output  32  status/response word to SoC PIO.
REQ-007 SHALL have port led_out  output  8  state debug: result[15:8] when idle, 8'hFF while busy.

Function
REQ-008 Command word: [31] req toggle, [30:28] opcode, [27:16] addr/count, [15:0] signed Q8.8 data.
REQ-009 Opcodes: 0 NOP, 1 WR_WEIGHT, 2 WR_INPUT, 3 SET_BIAS, 4 RUN, 5 CLR_ERR; 6-7 set error, no other effect.
REQ-010 Response word: [31] ack toggle, [30] busy, [29] error, [28:16] zero, [15:0] last result Q8.8.
REQ-011 A command SHALL be accepted in the IDLE cycle where to_hw_port_export[31] differs from the registered last-accepted toggle; the whole word is captured that cycle.
REQ-012 A toggle change while not IDLE SHALL stay pending and be accepted on the first IDLE cycle, using the word present then.
REQ-013 FSM states: IDLE, MAC, SAT, ACK; IDLE->ACK for opcodes 0-3,5-7 and rejected RUN; IDLE->MAC for valid RUN; MAC->SAT after N products; SAT->ACK; ACK->IDLE.
REQ-014 Non-RUN commands: write/clear performed at acceptance edge; ack toggle (=captured req toggle) visible 2 cycles after acceptance.
REQ-015 WR_WEIGHT/WR_INPUT with addr >= DEPTH SHALL set error and leave memory unchanged.
REQ-016 RUN with count N: acc = sum i<N of w[i]*x[i] (signed 16x16) + (bias <<< 8); one product per cycle; busy=1 from cycle after acceptance through ACK.
REQ-017 RUN latency: ack visible N+3 cycles after acceptance; N=0 yields saturated bias.
REQ-018 RUN with N > DEPTH SHALL set error, skip MAC, leave result unchanged, ack normally.
REQ-019 SAT: result = acc >>> 8, saturated to [-32768, 32767].
REQ-020 Error bit is sticky until CLR_ERR; CLR_ERR also acks.
REQ-021 Memories SHALL be single-port synchronous; read address presented one cycle ahead of use.

Reset
REQ-022 Reset SHALL force IDLE, to_sw_port_export=0, last-accepted toggle=0, bias=0, result=0, error=0, led_out=0.
REQ-023 Weight/input memory contents are not reset.
REQ-024 Reset mid-RUN SHALL abort without ack; after release a pending toggle=1 is accepted as a fresh command.

Configuration
REQ-025 Macro NEURON_RELU_EN defined: SAT clamps negative results to 0 after saturation.
REQ-026 Macro NEURON_RELU_EN undefined: signed saturated result passed unmodified.

Structure
REQ-027 Shared package neural_pkg SHALL hold opcode enum, FSM state enum, command/response field positions, Q8.8 fraction width.
REQ-028 One sub-module neuron_mac (multiply, accumulate, saturate, ReLU) SHALL be instantiated; memories and FSM stay in top.

Verification
REQ-029 WR_WEIGHT a0=0x0100, WR_INPUT a0=0x0200, SET_BIAS 0x0080, RUN N=1 -> result 0x0280, ack at acceptance+4.
REQ-030 Weights/inputs 0x7FFF at a0..3, bias 0, RUN N=4 -> result 0x7FFF, error 0.
REQ-031 w0=0xFF00, x0=0x0100, RUN N=1 -> 0xFF00 without NEURON_RELU_EN, 0x0000 with it.
REQ-032 WR_WEIGHT addr 64 (DEPTH 64) -> error 1, a63 unchanged; RUN N=65 -> error 1, result held; CLR_ERR -> error 0.
REQ-033 Toggle req during RUN N=8 -> second command accepted first IDLE cycle after first ack, two distinct acks.
REQ-034 Assert reset during MAC -> response 0, no ack; release with toggle 1, opcode 0 -> ack 1 two cycles after acceptance.
